// File: rtl/prom_arb_pkg.sv
// Shared constants, state encoding and request-search helpers for prom_fetch_arbiter.
package prom_arb_pkg;

  localparam int unsigned MAXREQ = 8;
  localparam int unsigned IDXW   = 3;

  typedef logic [0:0] state_t;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ADDR = 1'b1;

  function automatic logic [MAXREQ-1:0] onehot(input logic [IDXW-1:0] idx);
    logic [MAXREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // Returns {found, index} of the first set bit at or after start, wrapping within n.
  function automatic logic [IDXW:0] prio_search(input logic [MAXREQ-1:0] req,
                                                input logic [IDXW-1:0]   start,
                                                input int unsigned       n);
    logic [IDXW:0] res;
    int unsigned   j;
    res = '0;
    for (int unsigned i = 0; i < MAXREQ; i++) begin
      j = (32'(start) + i) % n;
      if (i < n && !res[IDXW] && req[IDXW'(j)]) res = {1'b1, IDXW'(j)};
    end
    return res;
  endfunction

endpackage

// File: rtl/prom_arb_rr.sv
// Combinational winner select; round-robin after ptr, or fixed lowest-index
// priority when PROM_ARB_FIXED_PRIO_EN is defined.
module prom_arb_rr
  import prom_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDXW-1:0] ptr,
  output logic            any_c,
  output logic [IDXW-1:0] win_c
);

  logic [MAXREQ-1:0] req_ext;
  logic [IDXW:0]     res;
  logic [IDXW-1:0]   start;

`ifdef PROM_ARB_FIXED_PRIO_EN
  logic ptr_unused;
  assign ptr_unused = ^ptr;
  assign start      = '0;
`else
  assign start = IDXW'((32'(ptr) + 1) % NREQ);
`endif

  always_comb begin
    req_ext = MAXREQ'(req);
    res     = prio_search(req_ext, start, NREQ);
  end

  assign any_c = res[IDXW];
  assign win_c = res[IDXW-1:0];

endmodule

// File: rtl/prom_fetch_arbiter.sv
// Round-robin arbiter sharing one registered PROM among NREQ burst requesters.
// Optional macro PROM_ARB_FIXED_PRIO_EN selects fixed lowest-index priority.
module prom_fetch_arbiter
  import prom_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned HEIGHT = 9,
  parameter int unsigned LENW   = 4
) (
  input  logic                   clk,
  input  logic                   clr_,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*HEIGHT-1:0] addr,
  input  logic [NREQ*LENW-1:0]   len,
  output logic [NREQ-1:0]        gnt,
  output logic [WIDTH-1:0]       rdata,
  output logic [NREQ-1:0]        rvalid,
  output logic [NREQ-1:0]        done,
  output logic [HEIGHT-1:0]      rom_a,
  input  logic [WIDTH-1:0]       rom_q,
  output logic                   rom_e1_,
  output logic                   rom_e2_,
  output logic                   rom_clr_,
  output logic                   rom_ps_
);

  state_t            state, state_d;
  logic [NREQ-1:0]   gnt_d, rvalid_d, done_d;
  logic [IDXW-1:0]   owner, owner_d, ptr, ptr_d;
  logic [LENW-1:0]   cnt, cnt_d;
  logic [HEIGHT-1:0] rom_a_d;
  logic              rom_e1_d, rom_e2_d;
  logic              any_c;
  logic [IDXW-1:0]   win_c;
  logic [MAXREQ-1:0] req_ext;

  assign rdata    = rom_q;
  assign rom_clr_ = clr_;
  assign rom_ps_  = 1'b1;
  assign req_ext  = MAXREQ'(req);

  prom_arb_rr #(.NREQ(NREQ)) u_rr (
    .req   (req),
    .ptr   (ptr),
    .any_c (any_c),
    .win_c (win_c)
  );

  // Next-state: grant in IDLE, stream addresses in ADDR, data phase one cycle behind.
  always_comb begin
    state_d  = state;
    gnt_d    = gnt;
    owner_d  = owner;
    ptr_d    = ptr;
    cnt_d    = cnt;
    rom_a_d  = rom_a;
    rom_e2_d = 1'b1;
    rom_e1_d = 1'b1;
    rvalid_d = '0;
    done_d   = '0;
    case (state)
      IDLE: begin
        if (any_c) begin
          state_d  = ADDR;
          gnt_d    = NREQ'(onehot(win_c));
          owner_d  = win_c;
`ifndef PROM_ARB_FIXED_PRIO_EN
          ptr_d    = win_c;
`endif
          cnt_d    = len[32'(win_c)*LENW +: LENW];
          rom_a_d  = addr[32'(win_c)*HEIGHT +: HEIGHT];
          rom_e2_d = 1'b0;
        end
      end
      ADDR: begin
        if (!req_ext[owner]) begin
          // Abort: the word fetched this cycle is never reported.
          state_d = IDLE;
          gnt_d   = '0;
        end else begin
          rvalid_d = NREQ'(onehot(owner));
          rom_e1_d = 1'b0;
          if (cnt == '0) begin
            done_d  = NREQ'(onehot(owner));
            state_d = IDLE;
            gnt_d   = '0;
          end else begin
            cnt_d    = LENW'(cnt - 1'b1);
            rom_a_d  = HEIGHT'(rom_a + 1'b1);
            rom_e2_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge clr_) begin
    if (!clr_) begin
      state   <= IDLE;
      gnt     <= '0;
      owner   <= '0;
      ptr     <= IDXW'(NREQ - 1);
      cnt     <= '0;
      rom_a   <= '0;
      rom_e2_ <= 1'b1;
      rom_e1_ <= 1'b1;
      rvalid  <= '0;
      done    <= '0;
    end else begin
      state   <= state_d;
      gnt     <= gnt_d;
      owner   <= owner_d;
      ptr     <= ptr_d;
      cnt     <= cnt_d;
      rom_a   <= rom_a_d;
      rom_e2_ <= rom_e2_d;
      rom_e1_ <= rom_e1_d;
      rvalid  <= rvalid_d;
      done    <= done_d;
    end
  end

endmodule
